nms_stream: RTL and testbench
=============================

# nms_stream

Parametrised, handshaked non-maximum suppression stage for the Canny edge pipeline. It sits between the gradient/angle stage and the hysteresis stage. It accepts one 3-pixel column per transfer (rows r-1, r, r+1) plus the quantised gradient angle of that column's centre pixel. It emits one thinned centre pixel per input column, with zero padding at strip edges, valid/ready backpressure, and an end-of-strip marker.

## Interface
- PIX_W, 5, pixel magnitude width
- IMG_W, 960, columns per strip (≥2)
- CNT_W, $clog2(IMG_W), column counter width
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  column offered
- in_ready  out  1  column accepted when in_valid&&in_ready
- in_pix0/1/2  in  PIX_W each  rows r-1, r, r+1 of the column
- in_angle  in  2  angle of in_pix1: 00 horiz, 01 diag /, 10 vert, 11 diag \
- out_valid  out  1  out_pix holds a result
- out_ready  in  1  consumer accepts when out_valid&&out_ready
- out_pix  out  PIX_W  suppressed centre magnitude
- out_last  out  1  high with result for column IMG_W-1

## Operation
- Window: three column registers L, C, R of 3 pixels, plus angle register ang_C aligned to C. The angle travels with its own column; it is not taken from the incoming column.
- Accept: the window shifts (L←C, C←R, R←input, ang_C←angle of the column entering C).
- Compare for centre p=C[1], neighbour pair by ang_C:
  - 00: L[1], R[1]
  - 01: L[2], R[0]
  - 10: C[0], C[2]
  - 11: L[0], R[2]
- out = 0 if either neighbour > p (strict), else p. Ties keep p. Comparison is unsigned PIX_W.
- Zero padding: a missing left column (column 0) and a missing right column (column IMG_W-1) read as all-zero.
- Column counter col (0..IMG_W-1) counts accepted columns within the strip.
- FSM states:
  - FILL: no column held. The accepted column becomes C with L=0. col→1. Next state RUN.
  - RUN: an accepted column i yields the result for column i-1 into the output register. If i==IMG_W-1, go to FLUSH.
  - FLUSH: in_ready=0. When the output register is free, emit the result for column IMG_W-1 with R=0 and out_last=1. Then clear L/C/R/ang_C and col, and return to FILL.
- in_ready = (state≠FLUSH) && (!out_valid || out_ready). The output register is the only buffer; a stall propagates combinationally through this equation.
- Exactly IMG_W outputs per IMG_W inputs. The first accept of a strip produces no output.

## Timing
- Reset values: out_valid=0, out_pix=0, out_last=0, state=FILL, col=0, window and ang_C=0. in_ready=1 immediately after reset.
- Latency:
  - Result for column i-1 is registered on the same edge column i is accepted, and is visible the next cycle.
  - Column IMG_W-1 result appears one cycle after FLUSH entry if out_ready held.
- Full throughput with out_ready=1: one column per cycle, plus one bubble per strip (FLUSH).
- out_valid&&!out_ready: out_pix/out_last held stable, in_ready=0, window frozen.
- Simultaneous output drain and input accept in one cycle is legal; the register reloads with no bubble.
- Reset mid-strip discards the window and the pending output. The next accepted column is column 0.

## Configuration
- NMS_THRESH_EN defined:
  - Adds inputs thr_lo, thr_hi (PIX_W) and output out_class (2).
  - out_class encoding: 00 = suppressed or out_pix<thr_lo; 01 = weak (thr_lo ≤ out_pix < thr_hi); 10 = strong (≥thr_hi). 11 is never produced.
  - out_class is registered alongside out_pix with identical timing. Reset value 00.
  - Thresholds are sampled on the cycle the result is registered.
- Undefined: those ports are absent; behaviour is otherwise identical.

## Structure
- Shared package nms_pkg:
  - angle enum (ANG_H, ANG_D45, ANG_V, ANG_D135)
  - FSM state enum (FILL, RUN, FLUSH)
  - edge class enum (CLS_NONE, CLS_WEAK, CLS_STRONG)
- Sub-module nms_cmp: combinational. Takes the 3×3 window and angle, returns the suppressed pixel. It is reused by the future colour/multi-channel variant.

## Test plan
- IMG_W=4, horizontal angle, centre row 3,7,5,9, out_ready=1 → outputs 0,7,0,9, out_last on 4th. Exact sequence: col0 3<7→0; col1 7≥3,5→7; col2 5<7→0; col3 9 vs R=0→9.
- Tie: angle 10, column {6,6,6} with 6-neighbours → out_pix=6 (kept).
- Each of the four angles with a single neighbour >p at the selected position → 0; the same value at an unselected position → p.
- Stall: out_ready=0 for 5 cycles mid-strip → in_ready=0, out_pix unchanged, no column lost; the output sequence matches the no-stall run.
- Two back-to-back strips of IMG_W=4 → exactly 8 outputs. One in_ready=0 bubble between strips. The second strip's column 0 sees L=0, not the first strip's data.
- Reset asserted after 2 columns, then a full strip → out_valid=0 during reset, and the 4 fresh outputs are correct. With NMS_THRESH_EN, thr_lo=4, thr_hi=8: values 0,7,9 → class 00,01,10.

Source files
------------

// File: rtl/nms_pkg.sv
// Shared types for the Canny non-maximum suppression stage: gradient angle,
// stream FSM state and hysteresis edge class.
package nms_pkg;

   typedef enum logic [1:0] {
      ANG_H    = 2'b00,
      ANG_D45  = 2'b01,
      ANG_V    = 2'b10,
      ANG_D135 = 2'b11
   } angle_e;

   typedef enum logic [1:0] {
      FILL  = 2'b00,
      RUN   = 2'b01,
      FLUSH = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      CLS_NONE   = 2'b00,
      CLS_WEAK   = 2'b01,
      CLS_STRONG = 2'b10
   } cls_e;

endpackage

// File: rtl/nms_cmp.sv
// Combinational 3x3 non-maximum suppression: keeps the centre pixel unless a
// neighbour along the gradient direction is strictly larger. Row index 0 is r-1.
module nms_cmp
   import nms_pkg::*;
#(
   parameter int PIX_W = 5
) (
   input  logic [2:0][PIX_W-1:0] col_l_i,
   input  logic [2:0][PIX_W-1:0] col_c_i,
   input  logic [2:0][PIX_W-1:0] col_r_i,
   input  angle_e                angle_i,
   output logic [PIX_W-1:0]      pix_o
);

   logic [PIX_W-1:0] p;
   logic [PIX_W-1:0] n_a;
   logic [PIX_W-1:0] n_b;

   always_comb begin
      p   = col_c_i[1];
      n_a = col_l_i[1];
      n_b = col_r_i[1];
      case (angle_i)
         ANG_H: begin
            n_a = col_l_i[1];
            n_b = col_r_i[1];
         end
         ANG_D45: begin
            n_a = col_l_i[2];
            n_b = col_r_i[0];
         end
         ANG_V: begin
            n_a = col_c_i[0];
            n_b = col_c_i[2];
         end
         ANG_D135: begin
            n_a = col_l_i[0];
            n_b = col_r_i[2];
         end
         default: ;
      endcase
      // Ties keep the centre, so flat ridges survive thinning.
      pix_o = ((n_a > p) || (n_b > p)) ? '0 : p;
   end

endmodule

// File: rtl/nms_stream.sv
// Handshaked streaming NMS stage: one 3-pixel column in, one thinned centre pixel out.
// Optional hysteresis pre-classification is enabled by defining NMS_THRESH_EN.
module nms_stream
   import nms_pkg::*;
#(
   parameter int PIX_W = 5,
   parameter int IMG_W = 960,
   parameter int CNT_W = $clog2(IMG_W)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pix0,
   input  logic [PIX_W-1:0] in_pix1,
   input  logic [PIX_W-1:0] in_pix2,
   input  logic [1:0]       in_angle,
`ifdef NMS_THRESH_EN
   input  logic [PIX_W-1:0] thr_lo,
   input  logic [PIX_W-1:0] thr_hi,
   output logic [1:0]       out_class,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_pix,
   output logic             out_last
);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        col_q, col_d;
   logic [2:0][PIX_W-1:0]   l_q, l_d;
   logic [2:0][PIX_W-1:0]   c_q, c_d;
   angle_e                  ang_q, ang_d;

   logic                    out_valid_q;
   logic [PIX_W-1:0]        out_pix_q;
   logic                    out_last_q;

   logic                    out_free;
   logic                    accept;
   logic                    load;
   logic                    last_d;
   logic [2:0][PIX_W-1:0]   in_col;
   logic [2:0][PIX_W-1:0]   r_col;
   logic [PIX_W-1:0]        cmp_pix;

   assign in_col   = {in_pix2, in_pix1, in_pix0};
   assign out_free = !out_valid_q || out_ready;
   assign in_ready = (state_q != FLUSH) && out_free;
   assign accept   = in_valid && in_ready;

   // The incoming column acts as R; during FLUSH the strip's right edge pads with zero.
   assign r_col = (state_q == FLUSH) ? '0 : in_col;

   nms_cmp #(.PIX_W(PIX_W)) u_cmp (
      .col_l_i (l_q),
      .col_c_i (c_q),
      .col_r_i (r_col),
      .angle_i (ang_q),
      .pix_o   (cmp_pix)
   );

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      l_d     = l_q;
      c_d     = c_q;
      ang_d   = ang_q;
      load    = 1'b0;
      last_d  = 1'b0;
      case (state_q)
         FILL: begin
            if (accept) begin
               l_d     = '0;
               c_d     = in_col;
               ang_d   = angle_e'(in_angle);
               col_d   = CNT_W'(1);
               state_d = RUN;
            end
         end
         RUN: begin
            if (accept) begin
               load  = 1'b1;
               l_d   = c_q;
               c_d   = in_col;
               ang_d = angle_e'(in_angle);
               col_d = col_q + CNT_W'(1);
               if (col_q == CNT_W'(IMG_W - 1)) begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (out_free) begin
               load    = 1'b1;
               last_d  = 1'b1;
               l_d     = '0;
               c_d     = '0;
               ang_d   = ANG_H;
               col_d   = '0;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FILL;
         col_q   <= '0;
         l_q     <= '0;
         c_q     <= '0;
         ang_q   <= ANG_H;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         l_q     <= l_d;
         c_q     <= c_d;
         ang_q   <= ang_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_pix_q   <= '0;
         out_last_q  <= 1'b0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         out_pix_q   <= cmp_pix;
         out_last_q  <= last_d;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pix   = out_pix_q;
   assign out_last  = out_last_q;

`ifdef NMS_THRESH_EN
   cls_e cls_q;

   // A suppressed (zero) magnitude never counts as an edge, whatever the thresholds.
   function automatic cls_e classify(input logic [PIX_W-1:0] pix,
                                     input logic [PIX_W-1:0] lo,
                                     input logic [PIX_W-1:0] hi);
      if ((pix == '0) || (pix < lo)) return CLS_NONE;
      else if (pix >= hi)            return CLS_STRONG;
      else                           return CLS_WEAK;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cls_q <= CLS_NONE;
      end else if (load) begin
         cls_q <= classify(cmp_pix, thr_lo, thr_hi);
      end
   end

   assign out_class = cls_q;
`endif

endmodule

// File: tb/tb_nms_stream.sv
// Self-checking bench for nms_stream (IMG_W=4) with a strip-level reference model.
module tb_nms_stream;
   import nms_pkg::*;

   localparam int PW = 5;
   localparam int W  = 4;

   typedef struct packed {
      logic [PW-1:0] p0;
      logic [PW-1:0] p1;
      logic [PW-1:0] p2;
      logic [1:0]    ang;
   } col_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [PW-1:0] in_pix0 = '0, in_pix1 = '0, in_pix2 = '0;
   logic [1:0]    in_angle = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [PW-1:0] out_pix;
   logic          out_last;
`ifdef NMS_THRESH_EN
   logic [PW-1:0] thr_lo = '0, thr_hi = '0;
   logic [1:0]    out_class;
   logic [1:0]    q_cls[$];
`endif

   int n_checks = 0;
   int n_pass   = 0;

   logic [PW-1:0] q_pix[$];
   logic          q_last[$];
   logic [PW-1:0] e_pix[$];
   logic          e_last[$];

   nms_stream #(.PIX_W(PW), .IMG_W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pix0   (in_pix0),
      .in_pix1   (in_pix1),
      .in_pix2   (in_pix2),
      .in_angle  (in_angle),
`ifdef NMS_THRESH_EN
      .thr_lo    (thr_lo),
      .thr_hi    (thr_hi),
      .out_class (out_class),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pix   (out_pix),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   // Records every output handshake (sampled mid-cycle, completes on the next rising edge).
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         q_pix.push_back(out_pix);
         q_last.push_back(out_last);
`ifdef NMS_THRESH_EN
         q_cls.push_back(out_class);
`endif
      end
   end

   function automatic col_t mk(input int p0, input int p1, input int p2, input int ang);
      col_t c;
      c.p0 = PW'(p0); c.p1 = PW'(p1); c.p2 = PW'(p2); c.ang = 2'(ang);
      return c;
   endfunction

   function automatic col_t rnd_col();
      return mk($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 3));
   endfunction

   // Reference: for each strip, each column is thinned against its own neighbours,
   // with zero columns beyond the strip edges.
   function automatic void model(input col_t cols[$]);
      col_t zero, l, c, r;
      logic [PW-1:0] a, b;
      zero = '0;
      for (int k = 0; k < cols.size(); k++) begin
         int j;
         j = k % W;
         c = cols[k];
         l = (j > 0)     ? cols[k-1] : zero;
         r = (j < W - 1) ? cols[k+1] : zero;
         case (c.ang)
            2'd0:    begin a = l.p1; b = r.p1; end
            2'd1:    begin a = l.p2; b = r.p0; end
            2'd2:    begin a = c.p0; b = c.p2; end
            default: begin a = l.p0; b = r.p2; end
         endcase
         e_pix.push_back((a > c.p1 || b > c.p1) ? '0 : c.p1);
         e_last.push_back(j == W - 1);
      end
   endfunction

   task automatic clear_q();
      q_pix.delete(); q_last.delete(); e_pix.delete(); e_last.delete();
`ifdef NMS_THRESH_EN
      q_cls.delete();
`endif
   endtask

   task automatic drive_cols(input col_t cols[$], input bit rnd_ready, output int bubbles);
      int i, guard;
      bit acc;
      i = 0; guard = 0; bubbles = 0;
      while (i < cols.size() && guard < 2000) begin
         in_valid = 1'b1;
         in_pix0  = cols[i].p0; in_pix1 = cols[i].p1; in_pix2 = cols[i].p2;
         in_angle = cols[i].ang;
         out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         acc = in_ready;
         if (!acc) bubbles++;
         @(posedge clk); #1;
         if (acc) i++;
         guard++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (i != cols.size()) $display("FAIL drive_timeout accepted=%0d required=%0d", i, cols.size());
      else n_pass++;
   endtask

   task automatic wait_outputs(input int n);
      int guard;
      out_ready = 1'b1; in_valid = 1'b0; guard = 0;
      while (q_pix.size() < n && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b want=0", out_valid); else n_pass++;
      n_checks++; if (out_pix !== '0) $display("FAIL rst_out_pix got=%0d want=0", out_pix); else n_pass++;
      n_checks++; if (out_last !== 1'b0) $display("FAIL rst_out_last got=%b want=0", out_last); else n_pass++;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b want=1", in_ready); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      col_t cols[$];
      int b;
      logic [PW-1:0] want[4] = '{0, 7, 0, 9};
      clear_q();
      cols = '{mk(0,3,0,0), mk(0,7,0,0), mk(0,5,0,0), mk(0,9,0,0)};
      drive_cols(cols, 1'b0, b);
      wait_outputs(4);
      n_checks++; if (q_pix.size() != 4) $display("FAIL basic_count got=%0d want=4", q_pix.size()); else n_pass++;
      for (int k = 0; k < 4 && k < q_pix.size(); k++) begin
         n_checks++;
         if (q_pix[k] !== want[k] || q_last[k] !== (k == 3))
            $display("FAIL basic_out[%0d] got pix=%0d last=%b want pix=%0d last=%b",
                     k, q_pix[k], q_last[k], want[k], k == 3);
         else n_pass++;
      end
   endtask

   task automatic test_tie();
      col_t cols[$];
      int b;
      clear_q();
      cols = '{mk(6,6,6,2), mk(6,6,6,2), mk(6,6,6,2), mk(6,6,6,2)};
      drive_cols(cols, 1'b0, b);
      wait_outputs(4);
      n_checks++; if (q_pix.size() != 4) $display("FAIL tie_count got=%0d want=4", q_pix.size()); else n_pass++;
      for (int k = 0; k < q_pix.size(); k++) begin
         n_checks++;
         if (q_pix[k] !== PW'(6)) $display("FAIL tie_out[%0d] got=%0d want=6", k, q_pix[k]);
         else n_pass++;
      end
   endtask

   task automatic test_angles();
      col_t cols[$];
      int b;
      for (int a = 0; a < 4; a++) begin
         for (int sel = 1; sel >= 0; sel--) begin
            clear_q();
            cols = '{mk(0,0,0,a), mk(0,5,0,a), mk(0,0,0,a), mk(0,0,0,a)};
            // Place a larger value either on the selected neighbour or on an unselected one.
            case (a)
               0: if (sel) cols[2].p1 = 9; else cols[1].p0 = 9;
               1: if (sel) cols[2].p0 = 9; else cols[2].p2 = 9;
               2: if (sel) cols[1].p0 = 9; else cols[2].p1 = 9;
               default: if (sel) cols[2].p2 = 9; else cols[2].p0 = 9;
            endcase
            model(cols);
            drive_cols(cols, 1'b0, b);
            wait_outputs(4);
            n_checks++;
            if (q_pix.size() < 2 || q_pix[1] !== (sel ? PW'(0) : PW'(5)))
               $display("FAIL angle%0d_sel%0d centre got=%0d want=%0d", a, sel,
                        (q_pix.size() > 1) ? q_pix[1] : PW'(0), sel ? 0 : 5);
            else n_pass++;
            for (int k = 0; k < e_pix.size(); k++) begin
               n_checks++;
               if (k >= q_pix.size() || q_pix[k] !== e_pix[k] || q_last[k] !== e_last[k])
                  $display("FAIL angle%0d_out[%0d] got=%0d want=%0d", a, k,
                           (k < q_pix.size()) ? q_pix[k] : PW'(0), e_pix[k]);
               else n_pass++;
            end
         end
      end
   endtask

   task automatic test_stall();
      col_t cols[$], head[$], tail[$];
      int b;
      clear_q();
      for (int k = 0; k < W; k++) cols.push_back(rnd_col());
      model(cols);
      head = cols[0:1];
      tail = cols[2:3];
      drive_cols(head, 1'b0, b);
      repeat (5) begin
         in_valid = 1'b1;
         in_pix0 = cols[2].p0; in_pix1 = cols[2].p1; in_pix2 = cols[2].p2; in_angle = cols[2].ang;
         out_ready = 1'b0;
         @(negedge clk);
         n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got=%b want=0", in_ready); else n_pass++;
         n_checks++;
         if (out_valid !== 1'b1 || out_pix !== e_pix[0])
            $display("FAIL stall_hold got valid=%b pix=%0d want valid=1 pix=%0d", out_valid, out_pix, e_pix[0]);
         else n_pass++;
         @(posedge clk); #1;
      end
      drive_cols(tail, 1'b0, b);
      wait_outputs(W);
      n_checks++; if (q_pix.size() != W) $display("FAIL stall_count got=%0d want=%0d", q_pix.size(), W); else n_pass++;
      for (int k = 0; k < e_pix.size() && k < q_pix.size(); k++) begin
         n_checks++;
         if (q_pix[k] !== e_pix[k] || q_last[k] !== e_last[k])
            $display("FAIL stall_out[%0d] got pix=%0d last=%b want pix=%0d last=%b",
                     k, q_pix[k], q_last[k], e_pix[k], e_last[k]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      col_t cols[$];
      int b;
      clear_q();
      for (int k = 0; k < 2 * W; k++) cols.push_back(rnd_col());
      cols[W-1].p1 = 31;
      cols[W]     = mk($urandom_range(0, 31), 10, $urandom_range(0, 31), 0);
      cols[W+1].p1 = 2;
      model(cols);
      drive_cols(cols, 1'b0, b);
      n_checks++; if (b != 1) $display("FAIL b2b_bubbles got=%0d want=1", b); else n_pass++;
      wait_outputs(2 * W);
      n_checks++; if (q_pix.size() != 2 * W) $display("FAIL b2b_count got=%0d want=%0d", q_pix.size(), 2 * W); else n_pass++;
      n_checks++;
      if (q_pix.size() <= W || q_pix[W] !== PW'(10))
         $display("FAIL b2b_strip2_col0 got=%0d want=10", (q_pix.size() > W) ? q_pix[W] : PW'(0));
      else n_pass++;
      for (int k = 0; k < e_pix.size() && k < q_pix.size(); k++) begin
         n_checks++;
         if (q_pix[k] !== e_pix[k] || q_last[k] !== e_last[k])
            $display("FAIL b2b_out[%0d] got pix=%0d last=%b want pix=%0d last=%b",
                     k, q_pix[k], q_last[k], e_pix[k], e_last[k]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      col_t cols[$];
      int b;
      for (int k = 0; k < 2; k++) cols.push_back(rnd_col());
      drive_cols(cols, 1'b0, b);
      reset = 1'b1;
      repeat (2) begin
         @(negedge clk);
         n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid got=%b want=0", out_valid); else n_pass++;
         @(posedge clk); #1;
      end
      reset = 1'b0;
      clear_q();
      cols.delete();
      for (int k = 0; k < W; k++) cols.push_back(rnd_col());
      model(cols);
      drive_cols(cols, 1'b0, b);
      wait_outputs(W);
      n_checks++; if (q_pix.size() != W) $display("FAIL rstmid_count got=%0d want=%0d", q_pix.size(), W); else n_pass++;
      for (int k = 0; k < e_pix.size() && k < q_pix.size(); k++) begin
         n_checks++;
         if (q_pix[k] !== e_pix[k] || q_last[k] !== e_last[k])
            $display("FAIL rstmid_out[%0d] got pix=%0d last=%b want pix=%0d last=%b",
                     k, q_pix[k], q_last[k], e_pix[k], e_last[k]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      col_t cols[$];
      int b;
      clear_q();
      for (int k = 0; k < 5 * W; k++) cols.push_back(rnd_col());
      model(cols);
      drive_cols(cols, 1'b1, b);
      wait_outputs(5 * W);
      n_checks++; if (q_pix.size() != 5 * W) $display("FAIL rand_count got=%0d want=%0d", q_pix.size(), 5 * W); else n_pass++;
      for (int k = 0; k < e_pix.size() && k < q_pix.size(); k++) begin
         n_checks++;
         if (q_pix[k] !== e_pix[k] || q_last[k] !== e_last[k])
            $display("FAIL rand_out[%0d] got pix=%0d last=%b want pix=%0d last=%b",
                     k, q_pix[k], q_last[k], e_pix[k], e_last[k]);
         else n_pass++;
      end
   endtask

`ifdef NMS_THRESH_EN
   task automatic test_thresh();
      col_t cols[$];
      int b;
      logic [1:0] want[4] = '{2'b00, 2'b01, 2'b00, 2'b10};
      clear_q();
      thr_lo = 4; thr_hi = 8;
      cols = '{mk(0,0,0,0), mk(0,7,0,0), mk(0,1,0,0), mk(0,9,0,0)};
      drive_cols(cols, 1'b0, b);
      wait_outputs(4);
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (k >= q_cls.size() || q_cls[k] !== want[k])
            $display("FAIL thresh_class[%0d] got=%b want=%b", k,
                     (k < q_cls.size()) ? q_cls[k] : 2'b11, want[k]);
         else n_pass++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_tie();
      test_angles();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_random();
`ifdef NMS_THRESH_EN
      test_thresh();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
